// File: rtl/down_counter_timer.sv
// Loadable down counter with start/done handshake, pause and abort.
// Optional continuous re-load at terminal count when AUTO_RELOAD_EN is defined.
module down_counter_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_pause,
  input  logic             i_abort,
  output logic [WIDTH-1:0] o_q,
  output logic             o_busy,
  output logic             o_paused,
  output logic             o_done,
  output logic             o_tc
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_d;
  logic             r_done;
  logic             w_done_d;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_q     <= ZERO;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_q     <= w_q_d;
      r_done  <= w_done_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_q_d     = r_q;
    w_done_d  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_q_d = i_load_val;
          if (i_load_val != ZERO) begin
            w_state_d = StRun;
          end else begin
            w_done_d = 1'b1;
          end
        end
      end
      StRun, StHold: begin
        if (i_abort) begin
          w_q_d     = ZERO;
          w_state_d = StIdle;
        end else if (i_pause) begin
          w_state_d = StHold;
        end else if (r_q > ONE) begin
          w_q_d     = r_q - ONE;
          w_state_d = StRun;
        end else if (r_q == ONE) begin
          w_q_d    = ZERO;
          w_done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
          w_state_d = StRun;
`else
          w_state_d = StIdle;
`endif
        end else begin
`ifdef AUTO_RELOAD_EN
          // Q==0 while active: the reload cycle after a terminal count.
          w_q_d     = i_load_val;
          w_state_d = (i_load_val != ZERO) ? StRun : StIdle;
`else
          w_state_d = StIdle;
`endif
        end
      end
      default: begin
        w_q_d     = ZERO;
        w_state_d = StIdle;
      end
    endcase
  end

  assign o_q      = r_q;
  assign o_busy   = (r_state == StRun) || (r_state == StHold);
  assign o_paused = (r_state == StHold);
  assign o_done   = r_done;
  assign o_tc     = (r_q == ZERO);

endmodule
